// File: rtl/knn_ctrl_pkg.sv
// knn_ctrl_pkg: shared state encoding, register map and bit indices for the KNN ready controller
package knn_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_FIN} knn_state_t;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_TIMEOUT = 2'd2;
  localparam logic [1:0] REG_LATENCY = 2'd3;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;
  localparam int STAT_OVR  = 3;
endpackage

// File: rtl/knn_sat_counter.sv
// knn_sat_counter: run-cycle counter that sticks at all-ones instead of wrapping
module knn_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic             at_max
);
  assign at_max = &q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && !at_max) q <= q + 1'b1;
endmodule

// File: rtl/knn_ready_handshake_ctrl.sv
// knn_ready_handshake_ctrl: Avalon-MM sequencer driving dados_pronto to the KNN core,
// with done/timeout status, run latency capture and a level interrupt.
module knn_ready_handshake_ctrl
  import knn_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TMO_DEFAULT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        dados_pronto,
  input  logic        knn_ack,
  input  logic        knn_done,
  output logic        irq
);
  knn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt, tmo_val, lat;
  logic at_max, irq_en, done, tmo_flag, ovr, set_done, set_tmo;
  logic wr, wr_ctrl, wr_stat, start_req, abort_req, launch, active, busy, tmo_hit;
  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == REG_CTRL);
  assign wr_stat   = wr & (address == REG_STATUS);
  assign abort_req = wr_ctrl & writedata[CTRL_ABORT];
  assign start_req = wr_ctrl & writedata[CTRL_START] & ~writedata[CTRL_ABORT];
  assign busy      = state_q != ST_IDLE;
  assign launch    = start_req & ~busy;
  assign active    = (state_q == ST_REQ) | (state_q == ST_WAIT);
  // a saturated counter can no longer reach any timeout value
  assign tmo_hit   = active & (tmo_val != '0) & ~at_max & (cnt + CNT_W'(1) == tmo_val);
  assign dados_pronto = state_q == ST_REQ;
  assign readdata = address == REG_CTRL    ? {29'b0, irq_en, 2'b0} :
                    address == REG_STATUS  ? {28'b0, ovr, tmo_flag, done, busy} :
                    address == REG_TIMEOUT ? 32'(tmo_val) : 32'(lat);
  knn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .reset(reset), .clr(launch), .en(active), .q(cnt), .at_max(at_max)
  );
  always_comb begin
    state_d  = state_q;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = start_req ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        state_d = abort_req ? ST_IDLE : tmo_hit ? ST_FIN : knn_ack ? ST_WAIT : ST_REQ;
        set_tmo = ~abort_req & tmo_hit;
      end
      ST_WAIT: begin
        state_d  = abort_req ? ST_IDLE : (knn_done | tmo_hit) ? ST_FIN : ST_WAIT;
        set_done = ~abort_req & knn_done;
        set_tmo  = ~abort_req & ~knn_done & tmo_hit;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  // status sets take priority over W1C clears in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      irq      <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      tmo_flag <= 1'b0;
      ovr      <= 1'b0;
      tmo_val  <= CNT_W'(TMO_DEFAULT);
      lat      <= '0;
    end else begin
      irq      <= irq_en & (done | tmo_flag);
      if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
      if (wr && address == REG_TIMEOUT) tmo_val <= writedata[CNT_W-1:0];
      if (state_q == ST_FIN) lat <= cnt;
      done     <= set_done | (~launch & done & ~(wr_stat & writedata[STAT_DONE]));
      tmo_flag <= set_tmo | (~launch & tmo_flag & ~(wr_stat & writedata[STAT_TMO]));
      ovr      <= (start_req & busy) | (~launch & ovr & ~(wr_stat & writedata[STAT_OVR]));
    end
endmodule

// File: tb/tb_knn_ready_handshake_ctrl.sv
// tb_knn_ready_handshake_ctrl: directed scenarios plus random traffic checked every cycle
// against a run-level behavioural model of the controller.
module tb_knn_ready_handshake_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write_n, knn_ack, knn_done;
  logic [31:0] writedata, readdata;
  logic        dados_pronto, irq;
  int errors = 0, checks = 0;
  localparam logic [31:0] TMO_RST = 32'd1000000;
  knn_ready_handshake_ctrl dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .dados_pronto(dados_pronto), .knn_ack(knn_ack), .knn_done(knn_done), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic run, acked, fin, done, to, ovr, irq_en, irq;
    logic [31:0] cnt, tmo, lat;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t mdl_reset();
    mdl_t r = '0;
    r.tmo = TMO_RST;
    return r;
  endfunction
  function automatic mdl_t step(input mdl_t o, input logic wr, input logic [1:0] a,
                                input logic [31:0] d, input logic ack, input logic dn);
    mdl_t n = o;
    logic start = wr && a == 2'd0 && d[0] && !d[1];
    logic abort = wr && a == 2'd0 && d[1];
    logic hit = o.tmo != 0 && o.cnt != 32'hFFFFFFFF && o.cnt + 32'd1 == o.tmo;
    n.irq = o.irq_en & (o.done | o.to);
    if (wr && a == 2'd1) begin
      if (d[1]) n.done = 1'b0;
      if (d[2]) n.to = 1'b0;
      if (d[3]) n.ovr = 1'b0;
    end
    if (wr && a == 2'd0) n.irq_en = d[2];
    if (wr && a == 2'd2) n.tmo = d;
    if (!o.run) begin
      if (start) begin
        n.run = 1'b1; n.acked = 1'b0; n.fin = 1'b0; n.cnt = '0;
        n.done = 1'b0; n.to = 1'b0; n.ovr = 1'b0;
      end
    end else if (o.fin) begin
      n.lat = o.cnt; n.run = 1'b0; n.fin = 1'b0;
      if (start) n.ovr = 1'b1;
    end else begin
      if (start) n.ovr = 1'b1;
      if (o.cnt != 32'hFFFFFFFF) n.cnt = o.cnt + 32'd1;
      if (abort) n.run = 1'b0;
      else if (o.acked && dn) begin n.fin = 1'b1; n.done = 1'b1; end
      else if (hit) begin n.fin = 1'b1; n.to = 1'b1; end
      else if (!o.acked && ack) n.acked = 1'b1;
    end
    return n;
  endfunction
  function automatic logic [31:0] exp_rd(input mdl_t o, input logic [1:0] a);
    return a == 2'd0 ? {29'b0, o.irq_en, 2'b0} :
           a == 2'd1 ? {28'b0, o.ovr, o.to, o.done, o.run} :
           a == 2'd2 ? o.tmo : o.lat;
  endfunction
  always @(posedge clk or posedge reset)
    m <= reset ? mdl_reset() : step(m, chipselect & ~write_n, address, writedata, knn_ack, knn_done);
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    check("cyc_dados_pronto", 32'(dados_pronto), 32'(m.run & ~m.acked & ~m.fin));
    check("cyc_irq", 32'(irq), 32'(m.irq));
    check("cyc_readdata", readdata, exp_rd(m, address));
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] want, input string nm);
    address = a;
    #1;
    check(nm, readdata, want);
  endtask
  initial begin
    int n;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    knn_ack = 1'b0; knn_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd(2, 32'd1000000, "rst_timeout");
    rd(1, 32'd0, "rst_status");
    check("rst_dados_pronto", 32'(dados_pronto), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    cyc();
    // normal run: 3 REQ cycles, 10 WAIT cycles
    bus_write(0, 32'h5);
    repeat (2) cyc();
    knn_ack = 1'b1; cyc(); knn_ack = 1'b0;
    repeat (9) cyc();
    knn_done = 1'b1; cyc(); knn_done = 1'b0;
    cyc();
    rd(1, 32'h2, "run_status");
    rd(3, 32'd13, "run_latency");
    check("run_irq", 32'(irq), 32'd1);
    bus_write(1, 32'h2);
    cyc();
    check("w1c_irq", 32'(irq), 32'd0);
    rd(1, 32'h0, "w1c_status");
    // timeout without ack
    bus_write(2, 32'd20);
    bus_write(0, 32'h1);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (dados_pronto) n++;
    end
    cyc();
    check("tmo_req_cycles", 32'(n), 32'd20);
    rd(1, 32'h4, "tmo_status");
    rd(3, 32'd20, "tmo_latency");
    // overrun
    bus_write(2, 32'd0);
    bus_write(0, 32'h1);
    knn_ack = 1'b1; cyc(); knn_ack = 1'b0;
    bus_write(0, 32'h1);
    rd(1, 32'h9, "ovr_status_busy");
    knn_done = 1'b1; cyc(); knn_done = 1'b0;
    cyc();
    rd(1, 32'hA, "ovr_status_end");
    rd(3, 32'd3, "ovr_latency");
    // abort in WAIT
    bus_write(0, 32'h1);
    knn_ack = 1'b1; cyc(); knn_ack = 1'b0;
    bus_write(0, 32'h2);
    rd(1, 32'h0, "abort_status");
    knn_done = 1'b1; cyc(); knn_done = 1'b0;
    cyc();
    rd(1, 32'h0, "abort_status_late");
    rd(3, 32'd3, "abort_latency");
    // done coincides with timeout
    bus_write(2, 32'd5);
    bus_write(0, 32'h1);
    knn_ack = 1'b1; cyc(); knn_ack = 1'b0;
    repeat (3) cyc();
    knn_done = 1'b1; cyc(); knn_done = 1'b0;
    cyc();
    rd(1, 32'h2, "tie_status");
    rd(3, 32'd5, "tie_latency");
    // asynchronous reset during REQ
    bus_write(0, 32'h1);
    check("pre_rst_dados_pronto", 32'(dados_pronto), 32'd1);
    #2 reset = 1'b1;
    #1 check("async_rst_dados_pronto", 32'(dados_pronto), 32'd0);
    cyc();
    reset = 1'b0;
    rd(2, 32'd1000000, "mid_rst_timeout");
    cyc();
    bus_write(2, 32'd15);
    repeat (3000) begin
      chipselect = $urandom_range(0, 5) == 0;
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = address == 2'd0 ? $urandom_range(0, 7) :
                   address == 2'd1 ? $urandom_range(0, 15) :
                   address == 2'd2 ? $urandom_range(0, 30) : $urandom;
      knn_ack    = $urandom_range(0, 3) == 0;
      knn_done   = $urandom_range(0, 3) == 0;
      cyc();
    end
    chipselect = 1'b0; write_n = 1'b1; knn_ack = 1'b0; knn_done = 1'b0;
    repeat (5) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
